// File: rtl/discus_pkg.sv
// Shared types and helpers for the discus return-address stack.
package discus_pkg;

  // Encoded directly as {push, pop} so decode is a plain cast.
  typedef enum logic [1:0] {
    NONE    = 2'b00,
    POP     = 2'b01,
    PUSH    = 2'b10,
    REPLACE = 2'b11
  } stack_op_t;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/discus_return_stack_if.sv
// Decode-side request/response bundle for the return-address stack.
interface discus_return_stack_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = discus_pkg::cnt_w(DEPTH);

  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] push_addr;
  logic              flush;
  logic              clear_err;
  logic [ADDR_W-1:0] top;
  logic              valid;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, pop, push_addr, flush, clear_err,
    input  top, valid, count, overflow, underflow
  );

  modport slave (
    input  push, pop, push_addr, flush, clear_err,
    output top, valid, count, overflow, underflow
  );
endinterface

// File: rtl/discus_lifo_mem.sv
// Unreset DEPTH x ADDR_W register file: one synchronous write port, one async read port.
module discus_lifo_mem #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [PTR_W-1:0]  i_waddr,
  input  logic [ADDR_W-1:0] i_wdata,
  input  logic [PTR_W-1:0]  i_raddr,
  output logic [ADDR_W-1:0] o_rdata
);

  logic [ADDR_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/discus_return_stack.sv
// Return-address stack with registered top-of-stack, occupancy count and
// sticky overflow/underflow flags over a circular LIFO store.
module discus_return_stack
  import discus_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  discus_return_stack_if.slave   rs
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  // r_head is the next write slot; the current top lives at r_head-1.
  logic [PTR_W-1:0]  r_head, w_nxt_head;
  logic [CNT_W-1:0]  r_count, w_nxt_count;
  logic [ADDR_W-1:0] r_top, w_nxt_top;
  logic              r_valid, w_nxt_valid;
  logic              r_ovf, w_nxt_ovf;
  logic              r_unf, w_nxt_unf;

  logic              w_we;
  logic [PTR_W-1:0]  w_waddr;
  logic [PTR_W-1:0]  w_rd_ptr;
  logic [ADDR_W-1:0] w_rd_data;
  logic              w_ovf_set, w_unf_set;
  logic              w_full, w_empty;
  stack_op_t         w_op;

  assign w_op     = stack_op_t'({rs.push, rs.pop});
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  // Entry that becomes top after a pop.
  assign w_rd_ptr = r_head - PTR_W'(2);

  discus_lifo_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (rs.push_addr),
    .i_raddr (w_rd_ptr),
    .o_rdata (w_rd_data)
  );

  always_comb begin
    w_nxt_head  = r_head;
    w_nxt_count = r_count;
    w_nxt_top   = r_top;
    w_nxt_valid = r_valid;
    w_we        = 1'b0;
    w_waddr     = r_head;
    w_ovf_set   = 1'b0;
    w_unf_set   = 1'b0;

    if (rs.flush) begin
      w_nxt_count = '0;
      w_nxt_top   = '0;
      w_nxt_valid = 1'b0;
    end else begin
      unique case (w_op)
        PUSH: begin
          w_ovf_set = w_full;
          // When full with WRAP, the head slot holds the oldest entry.
          if (!w_full || WRAP) begin
            w_we        = 1'b1;
            w_nxt_head  = r_head + PTR_W'(1);
            w_nxt_top   = rs.push_addr;
            w_nxt_valid = 1'b1;
            if (!w_full) w_nxt_count = r_count + CNT_W'(1);
          end
        end
        POP: begin
          if (w_empty) begin
            w_unf_set = 1'b1;
          end else begin
            w_nxt_head  = r_head - PTR_W'(1);
            w_nxt_count = r_count - CNT_W'(1);
            w_nxt_top   = (r_count == CNT_W'(1)) ? '0 : w_rd_data;
            w_nxt_valid = (r_count != CNT_W'(1));
          end
        end
        REPLACE: begin
          w_we      = 1'b1;
          w_nxt_top = rs.push_addr;
          if (w_empty) begin
            w_unf_set   = 1'b1;
            w_nxt_head  = r_head + PTR_W'(1);
            w_nxt_count = CNT_W'(1);
            w_nxt_valid = 1'b1;
          end else begin
            w_waddr = r_head - PTR_W'(1);
          end
        end
        default: ;
      endcase
    end

    w_nxt_ovf = w_ovf_set | (r_ovf & ~rs.clear_err);
    w_nxt_unf = w_unf_set | (r_unf & ~rs.clear_err);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_count <= '0;
      r_top   <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_head  <= w_nxt_head;
      r_count <= w_nxt_count;
      r_top   <= w_nxt_top;
      r_valid <= w_nxt_valid;
      r_ovf   <= w_nxt_ovf;
      r_unf   <= w_nxt_unf;
    end
  end

  assign rs.top       = r_top;
  assign rs.count     = r_count;
  assign rs.valid     = r_valid;
  assign rs.overflow  = r_ovf;
  assign rs.underflow = r_unf;

endmodule

// File: tb/tb_discus_return_stack.sv
// Scoreboard bench for discus_return_stack: one WRAP=1 and one WRAP=0 instance.
module tb_discus_return_stack;
  import discus_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned DP = 4;
  localparam int unsigned CW = cnt_w(DP);

  typedef struct packed {
    logic [AW-1:0] top;
    logic [CW-1:0] count;
    logic          valid;
    logic          ovf;
    logic          unf;
  } obs_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  discus_return_stack_if #(.ADDR_W(AW), .DEPTH(DP)) if_w ();
  discus_return_stack_if #(.ADDR_W(AW), .DEPTH(DP)) if_n ();

  discus_return_stack #(.ADDR_W(AW), .DEPTH(DP), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset_n(reset_n), .rs(if_w)
  );
  discus_return_stack #(.ADDR_W(AW), .DEPTH(DP), .WRAP(1'b0)) u_nowrap (
    .clk(clk), .reset_n(reset_n), .rs(if_n)
  );

  always #5 clk = ~clk;

  int            checks   = 0;
  int            failures = 0;
  bit            sel_wrap = 1'b1;
  logic [AW-1:0] mq[$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;
  obs_t          sb[$];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (wrap=%0d t=%0t)", tag, got, exp, sel_wrap, $time);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    if (sel_wrap) o = '{if_w.top, if_w.count, if_w.valid, if_w.overflow, if_w.underflow};
    else          o = '{if_n.top, if_n.count, if_n.valid, if_n.overflow, if_n.underflow};
    return o;
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    o.top   = (mq.size() != 0) ? mq[mq.size()-1] : '0;
    o.count = CW'(mq.size());
    o.valid = (mq.size() != 0);
    o.ovf   = m_ovf;
    o.unf   = m_unf;
    return o;
  endfunction

  task automatic compare(input string tag);
    obs_t e, o;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    o = observe();
    check({tag, "_top"},   int'(o.top),   int'(e.top));
    check({tag, "_count"}, int'(o.count), int'(e.count));
    check({tag, "_valid"}, int'(o.valid), int'(e.valid));
    check({tag, "_ovf"},   int'(o.ovf),   int'(e.ovf));
    check({tag, "_unf"},   int'(o.unf),   int'(e.unf));
  endtask

  task automatic drive(input logic p, input logic po, input logic [AW-1:0] a,
                       input logic f, input logic c);
    if_w.push = sel_wrap & p;  if_w.pop = sel_wrap & po; if_w.push_addr = a;
    if_w.flush = sel_wrap & f; if_w.clear_err = sel_wrap & c;
    if_n.push = !sel_wrap & p; if_n.pop = !sel_wrap & po; if_n.push_addr = a;
    if_n.flush = !sel_wrap & f; if_n.clear_err = !sel_wrap & c;
  endtask

  // Reference behaviour kept as an unbounded queue, back = top of stack.
  task automatic model_op(input logic p, input logic po, input logic [AW-1:0] a,
                          input logic f, input logic c);
    logic os, us;
    os = 1'b0;
    us = 1'b0;
    if (f) begin
      mq.delete();
    end else if (p && !po) begin
      if (mq.size() < int'(DP)) mq.push_back(a);
      else begin
        os = 1'b1;
        if (sel_wrap) begin
          void'(mq.pop_front());
          mq.push_back(a);
        end
      end
    end else if (!p && po) begin
      if (mq.size() == 0) us = 1'b1;
      else void'(mq.pop_back());
    end else if (p && po) begin
      if (mq.size() == 0) begin
        us = 1'b1;
        mq.push_back(a);
      end else mq[mq.size()-1] = a;
    end
    m_ovf = os | (m_ovf & ~c);
    m_unf = us | (m_unf & ~c);
  endtask

  task automatic step(input string tag, input logic p, input logic po,
                      input logic [AW-1:0] a, input logic f, input logic c);
    @(negedge clk);
    drive(p, po, a, f, c);
    model_op(p, po, a, f, c);
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic do_reset(input bit wrap);
    @(negedge clk);
    sel_wrap = wrap;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    reset_n = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    sb.push_back(model_out());
    compare("reset");
  endtask

  initial begin
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Basic push/pop order
    do_reset(1'b1);
    step("push10", 1, 0, 8'h10, 0, 0);
    step("push20", 1, 0, 8'h20, 0, 0);
    step("push30", 1, 0, 8'h30, 0, 0);
    check("plan_top30", int'(if_w.top), 'h30);
    check("plan_cnt3", int'(if_w.count), 3);
    for (int i = 0; i < 3; i++) step("pop3", 0, 1, '0, 0, 0);
    check("plan_valid0", int'(if_w.valid), 0);

    // WRAP=1: overwrite oldest, then underflow
    do_reset(1'b1);
    for (int i = 1; i <= 5; i++) step("wpush", 1, 0, AW'(i), 0, 0);
    for (int i = 0; i < 4; i++) step("wpop", 0, 1, '0, 0, 0);
    check("wrap_ovf", int'(if_w.overflow), 1);
    step("wpop5", 0, 1, '0, 0, 0);
    check("wrap_unf", int'(if_w.underflow), 1);

    // WRAP=0: reject on full
    do_reset(1'b0);
    for (int i = 1; i <= 5; i++) step("npush", 1, 0, AW'(i), 0, 0);
    check("nowrap_top4", int'(if_n.top), 4);
    for (int i = 0; i < 4; i++) step("npop", 0, 1, '0, 0, 0);
    // Flush leaves flag; clear_err then drops it
    step("nflush", 0, 0, '0, 1, 0);
    step("nclr", 0, 0, '0, 0, 1);

    // Replace
    do_reset(1'b1);
    step("pushAA", 1, 0, 8'hAA, 0, 0);
    step("repl55", 1, 1, 8'h55, 0, 0);
    check("repl_top55", int'(if_w.top), 'h55);
    step("pop_repl", 0, 1, '0, 0, 0);
    // Set wins over clear, then clear alone
    step("pop_empty_clr", 0, 1, '0, 0, 1);
    step("clr_only", 0, 0, '0, 0, 1);
    step("repl_empty", 1, 1, 8'h77, 0, 0);

    // Flush priority, then async reset mid-sequence
    step("push11", 1, 0, 8'h11, 0, 0);
    step("push22", 1, 0, 8'h22, 0, 0);
    step("flush_push", 1, 0, 8'h33, 1, 0);
    step("push44", 1, 0, 8'h44, 0, 0);
    step("pop_ovf_clr", 0, 1, '0, 0, 1);
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    sb.push_back(model_out());
    compare("async_rst");
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Random traffic on both policies
    for (int s = 0; s < 2; s++) begin
      do_reset(s == 0);
      for (int i = 0; i < 200; i++)
        step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             AW'($urandom_range(0, 255)), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 7) == 0));
    end

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
